// File: rtl/morty_pipeline_ctrl_pkg.sv
// Shared definitions for the Morty pipeline stall/flush controller.
// Holds the FSM state encoding, default timing values, the control-level
// bundle driven to the pipeline registers and helpers that build the
// recurring control patterns.
package morty_pipeline_ctrl_pkg;

  localparam int unsigned REG_W            = 5;
  localparam int unsigned STATE_W          = 2;
  localparam int unsigned WAIT_CNT_W       = 8;
  localparam int unsigned MD_LATENCY_DEF   = 32;
  localparam int unsigned DMEM_TIMEOUT_DEF = 255;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN       = 2'd0,
    ST_MD_BUSY   = 2'd1,
    ST_DMEM_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic stall_pc;
    logic stall_ifid;
    logic stall_idex;
    logic stall_exmem;
    logic clear_ifid;
    logic clear_idex;
    logic clear_exmem;
    logic clear_memwb;
    logic trap_redirect;
    logic md_done;
    logic bus_err;
  } ctrl_t;

  // Exception flush: squash everything younger than MEM and vector to trap.
  function automatic ctrl_t ctrl_flush();
    ctrl_t c;
    c = '0;
    c.clear_ifid    = 1'b1;
    c.clear_idex    = 1'b1;
    c.clear_exmem   = 1'b1;
    c.trap_redirect = 1'b1;
    return c;
  endfunction

  // Data memory wait: freeze the front of the pipe, drain a bubble into WB.
  function automatic ctrl_t ctrl_dmem_stall();
    ctrl_t c;
    c = '0;
    c.stall_pc    = 1'b1;
    c.stall_ifid  = 1'b1;
    c.stall_idex  = 1'b1;
    c.stall_exmem = 1'b1;
    c.clear_memwb = 1'b1;
    return c;
  endfunction

  // Mul/div occupancy: hold IF..EX, feed bubbles into MEM.
  function automatic ctrl_t ctrl_md_stall();
    ctrl_t c;
    c = '0;
    c.stall_pc   = 1'b1;
    c.stall_ifid = 1'b1;
    c.stall_idex = 1'b1;
    c.clear_exmem = 1'b1;
    return c;
  endfunction

  // Levels presented while reset is held.
  function automatic ctrl_t ctrl_reset();
    ctrl_t c;
    c = '0;
    c.clear_ifid  = 1'b1;
    c.clear_idex  = 1'b1;
    c.clear_exmem = 1'b1;
    c.clear_memwb = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/morty_pipeline_ctrl_if.sv
// Hazard-status and pipeline-control bundle between the Morty datapath
// (master: drives hazard status, receives stall/clear levels) and the
// stall/flush controller (slave).
interface morty_pipeline_ctrl_if;
  import morty_pipeline_ctrl_pkg::*;

  logic [REG_W-1:0]   id_rs1;
  logic [REG_W-1:0]   id_rs2;
  logic               id_uses_rs1;
  logic               id_uses_rs2;
  logic [REG_W-1:0]   ex_rd;
  logic               ex_mem_read;
  logic               ex_branch_taken;
  logic               ex_md_start;
  logic               imem_ready;
  logic               dmem_req;
  logic               dmem_ready;
  logic               exc_valid;

  logic               stall_pc;
  logic               stall_ifid;
  logic               stall_idex;
  logic               stall_exmem;
  logic               clear_ifid;
  logic               clear_idex;
  logic               clear_exmem;
  logic               clear_memwb;
  logic               trap_redirect;
  logic               md_done;
  logic               bus_err;
  logic [STATE_W-1:0] state_o;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, ex_md_start, imem_ready, dmem_req, dmem_ready,
           exc_valid,
    input  stall_pc, stall_ifid, stall_idex, stall_exmem, clear_ifid,
           clear_idex, clear_exmem, clear_memwb, trap_redirect, md_done,
           bus_err, state_o
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, ex_md_start, imem_ready, dmem_req, dmem_ready,
           exc_valid,
    output stall_pc, stall_ifid, stall_idex, stall_exmem, clear_ifid,
           clear_idex, clear_exmem, clear_memwb, trap_redirect, md_done,
           bus_err, state_o
  );

endinterface

// File: rtl/morty_pipeline_ctrl_load_use_detect.sv
// Load-use hazard detector: flags when the ID instruction reads a register
// that the load currently in EX has not yet produced. x0 never hazards.
// Ports: rs1/rs2 + uses_rs1/uses_rs2 (ID), rd + mem_read (EX), hazard out.
module morty_load_use_detect
  import morty_pipeline_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             uses_rs1,
  input  logic             uses_rs2,
  input  logic [REG_W-1:0] rd,
  input  logic             mem_read,
  output logic             hazard
);

  logic rd_live;

  assign rd_live = mem_read && (rd != '0);
  assign hazard  = rd_live && ((uses_rs1 && (rs1 == rd)) ||
                               (uses_rs2 && (rs2 == rd)));

endmodule

// File: rtl/morty_pipeline_ctrl.sv
// Central stall/flush controller for the five-stage Morty pipeline.
// Ports: clk, rst (async, active-low), bus (slave side of
// morty_pipeline_ctrl_if: hazard status in, stall/clear/trap/debug out).
// Control outputs are combinational from state and inputs.
// Optional feature: define DMEM_TIMEOUT_EN to abort data accesses that
// wait DMEM_TIMEOUT cycles with a bus_err pulse and trap flush.
module morty_pipeline_ctrl
  import morty_pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MD_LATENCY   = MD_LATENCY_DEF
`ifdef DMEM_TIMEOUT_EN
  ,
  parameter int unsigned DMEM_TIMEOUT = DMEM_TIMEOUT_DEF
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  morty_pipeline_ctrl_if.slave bus
);

  localparam int unsigned MD_CNT_W = $clog2(MD_LATENCY);

  state_e              state, state_n;
  logic [MD_CNT_W-1:0] md_cnt, md_cnt_n;
  ctrl_t               ctrl;
  logic                load_use;

`ifdef DMEM_TIMEOUT_EN
  logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_n;
`endif

  morty_load_use_detect u_load_use (
    .rs1      (bus.id_rs1),
    .rs2      (bus.id_rs2),
    .uses_rs1 (bus.id_uses_rs1),
    .uses_rs2 (bus.id_uses_rs2),
    .rd       (bus.ex_rd),
    .mem_read (bus.ex_mem_read),
    .hazard   (load_use)
  );

  // State and occupancy counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_RUN;
      md_cnt <= '0;
`ifdef DMEM_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      state  <= state_n;
      md_cnt <= md_cnt_n;
`ifdef DMEM_TIMEOUT_EN
      wait_cnt <= wait_cnt_n;
`endif
    end
  end

  // Next state and control levels.
  always_comb begin
    ctrl     = '0;
    state_n  = state;
    md_cnt_n = md_cnt;
`ifdef DMEM_TIMEOUT_EN
    wait_cnt_n = wait_cnt;
`endif
    case (state)
      ST_RUN: begin
        if (bus.exc_valid) begin
          ctrl = ctrl_flush();
        end else if (bus.dmem_req && !bus.dmem_ready) begin
          ctrl    = ctrl_dmem_stall();
          state_n = ST_DMEM_WAIT;
`ifdef DMEM_TIMEOUT_EN
          wait_cnt_n = '0;
`endif
        end else if (bus.ex_md_start) begin
          ctrl     = ctrl_md_stall();
          md_cnt_n = MD_CNT_W'(MD_LATENCY - 1);
          state_n  = ST_MD_BUSY;
        end else if (bus.ex_branch_taken) begin
          // Target PC loads regardless of fetch readiness.
          ctrl.clear_ifid = 1'b1;
          ctrl.clear_idex = 1'b1;
        end else if (load_use) begin
          ctrl.stall_pc   = 1'b1;
          ctrl.stall_ifid = 1'b1;
          ctrl.clear_idex = 1'b1;
        end else if (!bus.imem_ready) begin
          ctrl.stall_pc   = 1'b1;
          ctrl.clear_ifid = 1'b1;
        end
      end

      ST_MD_BUSY: begin
        // An exception from the older MEM instruction kills the op.
        if (bus.exc_valid) begin
          ctrl    = ctrl_flush();
          state_n = ST_RUN;
        end else if (md_cnt == '0) begin
          ctrl.md_done = 1'b1;
          state_n      = ST_RUN;
        end else begin
          ctrl     = ctrl_md_stall();
          md_cnt_n = md_cnt - MD_CNT_W'(1);
        end
      end

      ST_DMEM_WAIT: begin
        // Exceptions are held off until the access completes.
        if (bus.dmem_ready) begin
          state_n = ST_RUN;
`ifdef DMEM_TIMEOUT_EN
          wait_cnt_n = '0;
        end else if (wait_cnt == WAIT_CNT_W'(DMEM_TIMEOUT)) begin
          ctrl         = ctrl_flush();
          ctrl.bus_err = 1'b1;
          state_n      = ST_RUN;
          wait_cnt_n   = '0;
        end else begin
          ctrl       = ctrl_dmem_stall();
          wait_cnt_n = wait_cnt + WAIT_CNT_W'(1);
        end
`else
        end else begin
          ctrl = ctrl_dmem_stall();
        end
`endif
      end

      default: state_n = ST_RUN;
    endcase

    if (!rst) ctrl = ctrl_reset();
  end

  assign bus.stall_pc      = ctrl.stall_pc;
  assign bus.stall_ifid    = ctrl.stall_ifid;
  assign bus.stall_idex    = ctrl.stall_idex;
  assign bus.stall_exmem   = ctrl.stall_exmem;
  assign bus.clear_ifid    = ctrl.clear_ifid;
  assign bus.clear_idex    = ctrl.clear_idex;
  assign bus.clear_exmem   = ctrl.clear_exmem;
  assign bus.clear_memwb   = ctrl.clear_memwb;
  assign bus.trap_redirect = ctrl.trap_redirect;
  assign bus.md_done       = ctrl.md_done;
  assign bus.bus_err       = ctrl.bus_err;
  assign bus.state_o       = state;

endmodule
